// File: rtl/tc_ram_pkg.sv
// -----------------------------------------------------------------------------
// tc_ram_pkg
// Shared constants and types for the tc_ram_dual_port slice.
//   ADDR_W        : width of the per-port word address (16 bits)
//   clr_state_e   : states of the optional clear sweep (TC_RAM_CLEAR_EN)
//   addr_in_range : true when an address selects a physical word
// -----------------------------------------------------------------------------
package tc_ram_pkg;

  localparam int ADDR_W = 16;

  typedef enum logic [0:0] {
    CLR_IDLE  = 1'b0,
    CLR_CLEAR = 1'b1
  } clr_state_e;

  // One extra bit on the left so a depth of 65536 compares correctly.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                         input int unsigned       depth);
    return ({1'b0, addr} < (ADDR_W + 1)'(depth));
  endfunction

endpackage

// File: rtl/tc_ram_read_port.sv
// -----------------------------------------------------------------------------
// tc_ram_read_port
// One read port of the dual-port RAM: address range check, registered read
// data and the valid flag that accompanies it one cycle after the load.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   accept    : requests may be honoured this cycle (not in reset, not busy)
//   load      : read request
//   address   : word address
//   mem_data  : word currently stored at address (only meaningful in range)
//   addr_ok   : address selects a physical word (used by the write path too)
//   out       : registered read data, zero when no load was accepted
//   valid     : out carries the result of the previous cycle's load
// -----------------------------------------------------------------------------
module tc_ram_read_port
  import tc_ram_pkg::*;
#(
  parameter int BIT_WIDTH = 16,
  parameter int BIT_DEPTH = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 accept,
  input  logic                 load,
  input  logic [ADDR_W-1:0]    address,
  input  logic [BIT_WIDTH-1:0] mem_data,
  output logic                 addr_ok,
  output logic [BIT_WIDTH-1:0] out,
  output logic                 valid
);

  logic [BIT_WIDTH-1:0] out_d, out_q;
  logic                 valid_d, valid_q;

  // Next read data: out-of-range loads still complete, but return zero.
  always_comb begin
    addr_ok = addr_in_range(address, BIT_DEPTH);
    out_d   = {BIT_WIDTH{1'b0}};
    valid_d = 1'b0;
    if (accept && load) begin
      valid_d = 1'b1;
      if (addr_ok) begin
        out_d = mem_data;
      end else begin
        out_d = {BIT_WIDTH{1'b0}};
      end
    end else begin
      valid_d = 1'b0;
      out_d   = {BIT_WIDTH{1'b0}};
    end
  end

  // Read data and valid registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= {BIT_WIDTH{1'b0}};
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign out   = out_q;
  assign valid = valid_q;

endmodule

// File: rtl/tc_ram_dual_port.sv
// -----------------------------------------------------------------------------
// tc_ram_dual_port
// True dual-port RAM, BIT_DEPTH words of BIT_WIDTH bits, 1-cycle read latency,
// read-first on address collisions, port A wins a write/write collision.
// Optional feature macro: TC_RAM_CLEAR_EN -- after reset a sweep writes zero
// to every word, one per cycle, holding busy high until it finishes.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   busy                     : clear sweep running, requests ignored
//   load_a/b, save_a/b       : read / write requests per port
//   address_a/b              : 16-bit word address per port
//   in_a/b                   : write data per port
//   out_a/b, valid_a/b       : registered read data and its valid flag
// -----------------------------------------------------------------------------
module tc_ram_dual_port
  import tc_ram_pkg::*;
#(
  parameter int    UUID      = 0,
  parameter string NAME      = "",
  parameter int    BIT_WIDTH = 16,
  parameter int    BIT_DEPTH = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 busy,
  input  logic                 load_a,
  input  logic                 load_b,
  input  logic                 save_a,
  input  logic                 save_b,
  input  logic [ADDR_W-1:0]    address_a,
  input  logic [ADDR_W-1:0]    address_b,
  input  logic [BIT_WIDTH-1:0] in_a,
  input  logic [BIT_WIDTH-1:0] in_b,
  output logic [BIT_WIDTH-1:0] out_a,
  output logic [BIT_WIDTH-1:0] out_b,
  output logic                 valid_a,
  output logic                 valid_b
);

  localparam int IDX_W = (BIT_DEPTH > 1) ? $clog2(BIT_DEPTH) : 1;

  if ((BIT_WIDTH < 1) || (BIT_WIDTH > 64) || (BIT_DEPTH < 1) || (BIT_DEPTH > 65536)) begin : g_param_err
    $error("tc_ram_dual_port %s (uuid %0d): BIT_WIDTH or BIT_DEPTH out of range", NAME, UUID);
  end

  logic [BIT_WIDTH-1:0] mem_q [BIT_DEPTH];

  logic                 accept_s;
  logic                 addr_ok_a_s, addr_ok_b_s;
  logic [IDX_W-1:0]     idx_a_s, idx_b_s;
  logic [BIT_WIDTH-1:0] rd_a_s, rd_b_s;
  logic                 we_a_s, we_b_s;

`ifdef TC_RAM_CLEAR_EN
  clr_state_e  state_d, state_q;
  logic [16:0] cnt_d, cnt_q;
  logic        clr_we_s;

  // Clear sweep: reset parks the FSM in CLEAR at word 0, so the sweep starts
  // (or restarts) on the first cycle after rst drops.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (rst) begin
      state_d = CLR_CLEAR;
      cnt_d   = 17'd0;
    end else begin
      case (state_q)
        CLR_IDLE: begin
          state_d = CLR_IDLE;
          cnt_d   = 17'd0;
        end
        CLR_CLEAR: begin
          if (cnt_q == 17'(BIT_DEPTH - 1)) begin
            state_d = CLR_IDLE;
            cnt_d   = 17'd0;
          end else begin
            state_d = CLR_CLEAR;
            cnt_d   = cnt_q + 17'd1;
          end
        end
        default: begin
          state_d = CLR_IDLE;
          cnt_d   = 17'd0;
        end
      endcase
    end
  end

  // Clear FSM state and word counter.
  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
  end

  assign clr_we_s = !rst && (state_q == CLR_CLEAR);
  assign busy     = (state_q == CLR_CLEAR);
`else
  assign busy = 1'b0;
`endif

  assign accept_s = !rst && !busy;
  assign idx_a_s  = address_a[IDX_W-1:0];
  assign idx_b_s  = address_b[IDX_W-1:0];

  // Array read and write enables; out-of-range addresses never touch the array
  // and a B write colliding with an A write is dropped.
  always_comb begin
    if (addr_ok_a_s) begin
      rd_a_s = mem_q[idx_a_s];
    end else begin
      rd_a_s = {BIT_WIDTH{1'b0}};
    end
    if (addr_ok_b_s) begin
      rd_b_s = mem_q[idx_b_s];
    end else begin
      rd_b_s = {BIT_WIDTH{1'b0}};
    end
    we_a_s = accept_s && save_a && addr_ok_a_s;
    if (we_a_s && (idx_a_s == idx_b_s)) begin
      we_b_s = 1'b0;
    end else begin
      we_b_s = accept_s && save_b && addr_ok_b_s;
    end
  end

  // Storage array; reads above see the pre-write contents (read-first).
  always_ff @(posedge clk) begin
`ifdef TC_RAM_CLEAR_EN
    if (clr_we_s) begin
      mem_q[cnt_q[IDX_W-1:0]] <= {BIT_WIDTH{1'b0}};
    end else begin
      if (we_a_s) mem_q[idx_a_s] <= in_a;
      if (we_b_s) mem_q[idx_b_s] <= in_b;
    end
`else
    if (we_a_s) mem_q[idx_a_s] <= in_a;
    if (we_b_s) mem_q[idx_b_s] <= in_b;
`endif
  end

  tc_ram_read_port #(.BIT_WIDTH(BIT_WIDTH), .BIT_DEPTH(BIT_DEPTH)) u_port_a (
    .clk      (clk),
    .rst      (rst),
    .accept   (accept_s),
    .load     (load_a),
    .address  (address_a),
    .mem_data (rd_a_s),
    .addr_ok  (addr_ok_a_s),
    .out      (out_a),
    .valid    (valid_a)
  );

  tc_ram_read_port #(.BIT_WIDTH(BIT_WIDTH), .BIT_DEPTH(BIT_DEPTH)) u_port_b (
    .clk      (clk),
    .rst      (rst),
    .accept   (accept_s),
    .load     (load_b),
    .address  (address_b),
    .mem_data (rd_b_s),
    .addr_ok  (addr_ok_b_s),
    .out      (out_b),
    .valid    (valid_b)
  );

endmodule

// File: tb/tb_tc_ram_dual_port.sv
module tb_tc_ram_dual_port;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, busy;
  logic        load_a, load_b, save_a, save_b;
  logic [15:0] address_a, address_b, in_a, in_b;
  logic [15:0] out_a, out_b;
  logic        valid_a, valid_b;

  int checks   = 0;
  int failures = 0;
  logic [15:0] model [256];

`ifdef TC_RAM_CLEAR_EN
  localparam logic BUSY_IN_RST = 1'b1;
`else
  localparam logic BUSY_IN_RST = 1'b0;
`endif

  tc_ram_dual_port #(.UUID(1), .NAME("tb_ram"), .BIT_WIDTH(16), .BIT_DEPTH(256)) dut (
    .clk(clk), .rst(rst), .busy(busy),
    .load_a(load_a), .load_b(load_b), .save_a(save_a), .save_b(save_b),
    .address_a(address_a), .address_b(address_b), .in_a(in_a), .in_b(in_b),
    .out_a(out_a), .out_b(out_b), .valid_a(valid_a), .valid_b(valid_b)
  );

`ifdef TC_RAM_CLEAR_EN
  logic        c_rst, c_busy;
  logic        c_load_a, c_load_b, c_save_a, c_save_b;
  logic [15:0] c_address_a, c_address_b, c_in_a, c_in_b;
  logic [15:0] c_out_a, c_out_b;
  logic        c_valid_a, c_valid_b;

  tc_ram_dual_port #(.UUID(2), .NAME("tb_clr"), .BIT_WIDTH(16), .BIT_DEPTH(16)) dut_clr (
    .clk(clk), .rst(c_rst), .busy(c_busy),
    .load_a(c_load_a), .load_b(c_load_b), .save_a(c_save_a), .save_b(c_save_b),
    .address_a(c_address_a), .address_b(c_address_b), .in_a(c_in_a), .in_b(c_in_b),
    .out_a(c_out_a), .out_b(c_out_b), .valid_a(c_valid_a), .valid_b(c_valid_b)
  );
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    load_a = 1'b0; load_b = 1'b0; save_a = 1'b0; save_b = 1'b0;
    address_a = 16'h0; address_b = 16'h0; in_a = 16'h0; in_b = 16'h0;
  endtask

  task automatic wait_not_busy(input int budget);
    for (int i = 0; i < budget && busy !== 1'b0; i++) tick();
    chk("busy_timeout", {63'd0, busy}, 64'd0);
  endtask

  function automatic logic [15:0] pat(input int a);
    return 16'(a * 19 + 4096);
  endfunction

  initial begin
    idle();
    rst = 1'b1;
`ifdef TC_RAM_CLEAR_EN
    c_rst = 1'b1; c_load_a = 1'b0; c_load_b = 1'b0; c_save_a = 1'b0; c_save_b = 1'b0;
    c_address_a = 16'h0; c_address_b = 16'h0; c_in_a = 16'h0; c_in_b = 16'h0;
`endif
    // Reset state, with a load request that must be ignored.
    load_a = 1'b1;
    tick();
    chk("rst_out_a", out_a, 16'h0);
    chk("rst_valid_a", valid_a, 1'b0);
    chk("rst_out_b", out_b, 16'h0);
    chk("rst_valid_b", valid_b, 1'b0);
    chk("rst_busy", busy, BUSY_IN_RST);
    rst = 1'b0;
    idle();
    wait_not_busy(400);

    // Fill every word with a known pattern, both ports at once.
    for (int i = 0; i < 128; i++) begin
      save_a = 1'b1; address_a = 16'(2 * i);     in_a = pat(2 * i);
      save_b = 1'b1; address_b = 16'(2 * i + 1); in_b = pat(2 * i + 1);
      model[2 * i] = pat(2 * i);
      model[2 * i + 1] = pat(2 * i + 1);
      tick();
    end
    chk("fill_valid_a", valid_a, 1'b0);

    // Write on A, read back on B.
    idle(); save_a = 1'b1; address_a = 16'h0010; in_a = 16'hBEEF; model[16] = 16'hBEEF;
    tick();
    idle(); load_b = 1'b1; address_b = 16'h0010;
    tick();
    chk("xport_out_b", out_b, 16'hBEEF);
    chk("xport_valid_b", valid_b, 1'b1);
    chk("xport_valid_a", valid_a, 1'b0);
    idle();
    tick();
    chk("noload_out_b", out_b, 16'h0);
    chk("noload_valid_b", valid_b, 1'b0);

    // Same-port read-first.
    save_a = 1'b1; address_a = 16'h0005; in_a = 16'h1111;
    tick();
    load_a = 1'b1; in_a = 16'h2222; model[5] = 16'h2222;
    tick();
    chk("rf_old_a", out_a, 16'h1111);
    chk("rf_old_valid_a", valid_a, 1'b1);
    idle(); load_a = 1'b1; address_a = 16'h0005;
    tick();
    chk("rf_new_a", out_a, 16'h2222);

    // Cross-port read-first: B writes while A reads.
    save_b = 1'b1; address_b = 16'h0005; in_b = 16'h3333; model[5] = 16'h3333;
    tick();
    chk("xrf_old_a", out_a, 16'h2222);
    idle(); load_a = 1'b1; address_a = 16'h0005;
    tick();
    chk("xrf_new_a", out_a, 16'h3333);

    // Write collision: A wins.
    idle();
    save_a = 1'b1; address_a = 16'h0007; in_a = 16'hAAAA;
    save_b = 1'b1; address_b = 16'h0007; in_b = 16'h5555;
    model[7] = 16'hAAAA;
    tick();
    idle(); load_a = 1'b1; address_a = 16'h0007; load_b = 1'b1; address_b = 16'h0007;
    tick();
    chk("coll_out_a", out_a, 16'hAAAA);
    chk("coll_out_b", out_b, 16'hAAAA);

    // Top-of-range and out-of-range loads.
    idle(); load_a = 1'b1; address_a = 16'd255; load_b = 1'b1; address_b = 16'd256;
    tick();
    chk("top_out_a", out_a, model[255]);
    chk("oor_out_b", out_b, 16'h0);
    chk("oor_valid_b", valid_b, 1'b1);
    idle(); load_a = 1'b1; address_a = 16'd300;
    tick();
    chk("oor_out_a", out_a, 16'h0);
    chk("oor_valid_a", valid_a, 1'b1);

    // Out-of-range saves must not alias onto low words.
    idle();
    save_b = 1'b1; address_b = 16'd300; in_b = 16'hDEAD;
    save_a = 1'b1; address_a = 16'd256; in_a = 16'hF00D;
    tick();
    idle();
    for (int i = 0; i < 128; i++) begin
      load_a = 1'b1; address_a = 16'(2 * i);
      load_b = 1'b1; address_b = 16'(2 * i + 1);
      tick();
      chk($sformatf("rb_a_%0d", 2 * i), out_a, model[2 * i]);
      chk($sformatf("rb_b_%0d", 2 * i + 1), out_b, model[2 * i + 1]);
    end

    // Requests during reset are ignored; contents survive reset.
    idle(); rst = 1'b1;
    save_a = 1'b1; address_a = 16'h0020; in_a = 16'h1234;
    load_b = 1'b1; address_b = 16'h0020;
    tick();
    chk("rstreq_valid_b", valid_b, 1'b0);
    chk("rstreq_out_b", out_b, 16'h0);
    rst = 1'b0; idle();
`ifdef TC_RAM_CLEAR_EN
    for (int i = 0; i < 256; i++) model[i] = 16'h0;
`endif
    wait_not_busy(400);
    load_a = 1'b1; address_a = 16'h0020; load_b = 1'b1; address_b = 16'h0010;
    tick();
    chk("keep_out_a", out_a, model[32]);
    chk("keep_out_b", out_b, model[16]);

`ifdef TC_RAM_CLEAR_EN
    begin
      int n;
      // Bring the small instance out of its first sweep, then fill with ones.
      c_rst = 1'b0;
      for (int i = 0; i < 100 && c_busy !== 1'b0; i++) tick();
      chk("clr_init_busy", c_busy, 1'b0);
      for (int i = 0; i < 8; i++) begin
        c_save_a = 1'b1; c_address_a = 16'(2 * i);     c_in_a = 16'hFFFF;
        c_save_b = 1'b1; c_address_b = 16'(2 * i + 1); c_in_b = 16'hFFFF;
        tick();
      end
      c_save_a = 1'b0; c_save_b = 1'b0;
      c_rst = 1'b1;
      tick();
      c_rst = 1'b0; c_load_a = 1'b1; c_address_a = 16'h0003;
      n = 0;
      for (int k = 0; k < 100 && c_busy === 1'b1; k++) begin
        n++;
        chk("clr_busy_valid_a", c_valid_a, 1'b0);
        tick();
      end
      chk("clr_busy_len", n, 16);
      c_load_a = 1'b0;
      for (int i = 0; i < 16; i++) begin
        c_load_a = 1'b1; c_address_a = 16'(i);
        tick();
        chk($sformatf("clr_rb_%0d", i), c_out_a, 16'h0);
      end
      c_load_a = 1'b0;
      // Restart mid-sweep.
      c_rst = 1'b1;
      tick();
      c_rst = 1'b0;
      for (int k = 0; k < 8; k++) tick();
      chk("clr_mid_busy", c_busy, 1'b1);
      c_rst = 1'b1;
      tick();
      tick();
      c_rst = 1'b0;
      n = 0;
      for (int k = 0; k < 100 && c_busy === 1'b1; k++) begin
        n++;
        tick();
      end
      chk("clr_restart_len", n, 16);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tc_ram_dual_port.md
TC_RAM_DUAL_PORT -- requirements
Module: tc_ram_dual_port

Interface
REQ-001 The block SHALL take parameter UUID, default 0: component identifier, no functional effect.
REQ-002 The block SHALL take parameter NAME, default "": instance label, no functional effect.
REQ-003 The block SHALL take parameter BIT_WIDTH, default 16: word width, legal range 1..64.
REQ-004 The block SHALL take parameter BIT_DEPTH, default 256: word count, legal range 1..65536.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: one clock; reset is synchronous and active-high.
REQ-007 The block SHALL have port busy, output, 1 bit: clear sweep in progress; requests are ignored while high.
REQ-008 The block SHALL have ports load_a and load_b, input, 1 bit each: read request per port.
REQ-009 The block SHALL have ports save_a and save_b, input, 1 bit each: write request per port.
REQ-010 The block SHALL have ports address_a and address_b, input, 16 bits each: word address per port.
REQ-011 The block SHALL have ports in_a and in_b, input, BIT_WIDTH each: write data per port.
REQ-012 The block SHALL have ports out_a and out_b, output, BIT_WIDTH each: registered read data per port.
REQ-013 The block SHALL have ports valid_a and valid_b, output, 1 bit each: the matching out holds data from the previous cycle's load.

Function
REQ-014 The storage SHALL hold exactly BIT_DEPTH words, at addresses 0..BIT_DEPTH-1.
REQ-015 Read latency SHALL be 1 cycle: a load accepted in cycle N SHALL drive out_x = mem[address_x] and valid_x = 1 in cycle N+1.
REQ-016 If no load is accepted in cycle N, out_x SHALL be 0 and valid_x SHALL be 0 in cycle N+1.
REQ-017 A save accepted in cycle N SHALL update mem[address_x] with in_x at the end of cycle N.
REQ-018 A load and a save on the same address in the same cycle, on either port, SHALL return the old data (read-first).
REQ-019 If both ports save to the same address in the same cycle, port A's data SHALL be stored and port B's write discarded.
REQ-020 A load with address >= BIT_DEPTH SHALL return out = 0 with valid = 1; a save to such an address SHALL be ignored.
REQ-021 Load and save on one port in the same cycle SHALL both be honoured.
REQ-022 While busy = 1, all loads and saves SHALL be ignored; valid_a and valid_b SHALL stay 0.

Reset
REQ-023 When rst = 1 at a rising edge, out_a, out_b, valid_a and valid_b SHALL be 0 in the next cycle.
REQ-024 While rst = 1, all requests SHALL be ignored.
REQ-025 Without the clear feature, memory contents SHALL be preserved across reset.

Configuration
REQ-026 Macro TC_RAM_CLEAR_EN SHALL control the clear sweep.
REQ-027 With TC_RAM_CLEAR_EN defined, the block SHALL be a two-state FSM, IDLE and CLEAR.
REQ-028 Deasserting rst SHALL enter CLEAR with counter 0; busy SHALL be 1 in CLEAR.
REQ-029 In CLEAR, the block SHALL write 0 to one word per cycle.
REQ-030 After writing word BIT_DEPTH-1, the FSM SHALL return to IDLE; busy SHALL fall exactly BIT_DEPTH cycles after rst deasserts.
REQ-031 Reasserting rst mid-sweep SHALL restart the sweep at word 0 once rst deasserts.
REQ-032 The counter SHALL be 17 bits wide so BIT_DEPTH = 65536 terminates correctly.
REQ-033 Without TC_RAM_CLEAR_EN, busy SHALL be tied to 0, no FSM or counter SHALL exist, and memory SHALL power up unknown.

Structure
REQ-034 Package tc_ram_pkg SHALL hold the address width constant (16) and the clear FSM state enumeration.
REQ-035 Sub-module tc_ram_read_port SHALL implement the per-port address range check, read register and valid flag, and SHALL be instantiated twice.

Verification
REQ-036 BIT_WIDTH=16, BIT_DEPTH=256, clear disabled: save_a addr 0x10 data 0xBEEF in cycle 0, load_b addr 0x10 in cycle 1 -> out_b = 0xBEEF, valid_b = 1 in cycle 2.
REQ-037 Mem[5] = 0x1111; save_a and load_a addr 5 data 0x2222 in the same cycle -> out_a = 0x1111 next cycle, then 0x2222 on a repeat load.
REQ-038 save_a 0xAAAA and save_b 0x5555 both to addr 7 in the same cycle -> a later read of addr 7 returns 0xAAAA.
REQ-039 load_a addr 300 with BIT_DEPTH=256 -> out_a = 0, valid_a = 1; save_b addr 300 -> no word changes, checked by full readback.
REQ-040 TC_RAM_CLEAR_EN, BIT_DEPTH=16, memory pre-filled with 0xFFFF: release rst -> busy high 16 cycles and loads ignored; all words read 0 afterwards.
REQ-041 TC_RAM_CLEAR_EN: reassert rst at sweep cycle 8 for 2 cycles -> after release busy lasts 16 more cycles.
